// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants and types for the sequential divider slice.
//   DATA_W  : operand / result width (matches the 8-bit add/subtract datapath)
//   CNT_W   : width of the restoring-step bit counter
//   state_t : control FSM states (IDLE, CALC, DONE)
// Optional feature macro used elsewhere in the slice: SEQ_DIVIDER_SIGNED_EN
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : div_pkg

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Request/result bundle for seq_divider.
//   start_i     : request a division (honoured only while the divider is idle)
//   dividend_i  : dividend, captured on an accepted start
//   divisor_i   : divisor, captured on an accepted start
//   signed_i    : two's-complement mode select (only with SEQ_DIVIDER_SIGNED_EN)
//   busy_o      : divider is in CALC or DONE
//   done_o      : one-cycle pulse, results valid in that cycle
//   quotient_o  : registered quotient
//   remainder_o : registered remainder
//   div_zero_o  : last operation had a zero divisor
// Modports: master drives the request side, slave is the divider.
// -----------------------------------------------------------------------------
import div_pkg::*;

interface seq_divider_if;

    logic              start_i;
    logic [DATA_W-1:0] dividend_i;
    logic [DATA_W-1:0] divisor_i;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic              signed_i;
`endif
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] quotient_o;
    logic [DATA_W-1:0] remainder_o;
    logic              div_zero_o;

`ifdef SEQ_DIVIDER_SIGNED_EN
    modport master (
        output start_i, dividend_i, divisor_i, signed_i,
        input  busy_o, done_o, quotient_o, remainder_o, div_zero_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i, signed_i,
        output busy_o, done_o, quotient_o, remainder_o, div_zero_o
    );
`else
    modport master (
        output start_i, dividend_i, divisor_i,
        input  busy_o, done_o, quotient_o, remainder_o, div_zero_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
        output busy_o, done_o, quotient_o, remainder_o, div_zero_o
    );
`endif

endinterface : seq_divider_if

// File: rtl/seq_divider_add_subtract.sv
// -----------------------------------------------------------------------------
// add_subtract
// The shared 8-bit adder/subtractor.
//   a, b      : operands
//   add_sub   : 0 = a + b, 1 = a - b (two's complement: a + ~b + 1)
//   sum       : low DATA_W bits of the result
//   carry_out : carry out of the MSB; in subtract mode 1 means no borrow (a >= b)
// -----------------------------------------------------------------------------
import div_pkg::*;

module add_subtract (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              add_sub,
    output logic [DATA_W-1:0] sum,
    output logic              carry_out
);

    logic [DATA_W:0] total_s;

    // Single ripple adder; subtraction inverts b and injects the +1 as carry-in.
    always_comb begin
        total_s = {1'b0, a}
                + {1'b0, (b ^ {DATA_W{add_sub}})}
                + {{DATA_W{1'b0}}, add_sub};
    end

    assign sum       = total_s[DATA_W-1:0];
    assign carry_out = total_s[DATA_W];

endmodule : add_subtract

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider: one quotient bit per clock, MSB first.
// A start with a nonzero divisor takes 8 CALC cycles and then a single DONE
// cycle; a zero divisor skips CALC and reports quotient all-ones,
// remainder = dividend and div_zero_o = 1.
// Ports:
//   clk_i : sole clock, rising edge
//   rst_i : synchronous, active-high reset (wins over everything)
//   bus   : seq_divider_if.slave request/result bundle
// Optional macro SEQ_DIVIDER_SIGNED_EN adds bus.signed_i: operands are then
// treated as two's complement, magnitudes go through the unsigned core and
// signs are fixed up when the result is registered (quotient truncates toward
// zero, remainder follows the dividend's sign).
// -----------------------------------------------------------------------------
import div_pkg::*;

module seq_divider (
    input  logic         clk_i,
    input  logic         rst_i,
    seq_divider_if.slave bus
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    // work_r starts as the dividend; its MSB feeds each step while quotient
    // bits shift in at the LSB, so after 8 steps it holds the raw quotient.
    logic [DATA_W-1:0] work_r;
    logic [DATA_W-1:0] divisor_r;
    logic [DATA_W-1:0] part_rem_r;
    logic [DATA_W-1:0] quotient_r;
    logic [DATA_W-1:0] remainder_r;
    logic              div_zero_r;
    logic              busy_r;
    logic              done_r;

    logic [DATA_W-1:0] cap_dvd_s;
    logic [DATA_W-1:0] cap_dvs_s;
    logic [DATA_W-1:0] shift_low_s;
    logic              shift_top_s;
    logic [DATA_W-1:0] diff_s;
    logic              carry_s;
    logic              step_ok_s;
    logic [DATA_W-1:0] rem_step_s;
    logic [DATA_W-1:0] quo_step_s;
    logic [DATA_W-1:0] fin_quo_s;
    logic [DATA_W-1:0] fin_rem_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic              neg_quo_r;
    logic              neg_rem_r;
    logic              neg_dvd_s;
    logic              neg_dvs_s;
`endif

    // Shifted partial remainder {R, next dividend bit}: top bit kept separately.
    assign shift_top_s = part_rem_r[DATA_W-1];
    assign shift_low_s = {part_rem_r[DATA_W-2:0], work_r[DATA_W-1]};

    add_subtract u_add_subtract (
        .a         (shift_low_s),
        .b         (divisor_r),
        .add_sub   (1'b1),
        .sum       (diff_s),
        .carry_out (carry_s)
    );

    // One restoring step: a set top bit means the 9-bit value exceeds any divisor.
    always_comb begin
        step_ok_s = shift_top_s | carry_s;
        if (step_ok_s) begin
            rem_step_s = diff_s;
        end else begin
            rem_step_s = shift_low_s;
        end
        quo_step_s = {work_r[DATA_W-2:0], step_ok_s};
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    // Operand magnitudes for the unsigned core and result sign fix-up.
    always_comb begin
        neg_dvd_s = bus.signed_i & bus.dividend_i[DATA_W-1];
        neg_dvs_s = bus.signed_i & bus.divisor_i[DATA_W-1];
        if (neg_dvd_s) begin
            cap_dvd_s = {DATA_W{1'b0}} - bus.dividend_i;
        end else begin
            cap_dvd_s = bus.dividend_i;
        end
        if (neg_dvs_s) begin
            cap_dvs_s = {DATA_W{1'b0}} - bus.divisor_i;
        end else begin
            cap_dvs_s = bus.divisor_i;
        end
        if (neg_quo_r) begin
            fin_quo_s = {DATA_W{1'b0}} - quo_step_s;
        end else begin
            fin_quo_s = quo_step_s;
        end
        if (neg_rem_r) begin
            fin_rem_s = {DATA_W{1'b0}} - rem_step_s;
        end else begin
            fin_rem_s = rem_step_s;
        end
    end
`else
    // Unsigned build: operands and results pass straight through.
    always_comb begin
        cap_dvd_s = bus.dividend_i;
        cap_dvs_s = bus.divisor_i;
        fin_quo_s = quo_step_s;
        fin_rem_s = rem_step_s;
    end
`endif

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.divisor_i == {DATA_W{1'b0}}) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand capture, per-cycle step, and result registers (updated only at the end).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r       <= {CNT_W{1'b0}};
            work_r      <= {DATA_W{1'b0}};
            divisor_r   <= {DATA_W{1'b0}};
            part_rem_r  <= {DATA_W{1'b0}};
            quotient_r  <= {DATA_W{1'b0}};
            remainder_r <= {DATA_W{1'b0}};
            div_zero_r  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_r   <= 1'b0;
            neg_rem_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start_i) begin
                        work_r     <= cap_dvd_s;
                        divisor_r  <= cap_dvs_s;
                        part_rem_r <= {DATA_W{1'b0}};
                        cnt_r      <= 3'd7;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_quo_r  <= neg_dvd_s ^ neg_dvs_s;
                        neg_rem_r  <= neg_dvd_s;
`endif
                        // Zero divisor: results are known now, no CALC pass.
                        if (bus.divisor_i == {DATA_W{1'b0}}) begin
                            quotient_r  <= {DATA_W{1'b1}};
                            remainder_r <= bus.dividend_i;
                            div_zero_r  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    part_rem_r <= rem_step_s;
                    work_r     <= quo_step_s;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        quotient_r  <= fin_quo_s;
                        remainder_r <= fin_rem_s;
                        div_zero_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy_o      = busy_r;
    assign bus.done_o      = done_r;
    assign bus.quotient_o  = quotient_r;
    assign bus.remainder_o = remainder_r;
    assign bus.div_zero_o  = div_zero_r;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed, table-driven bench for seq_divider plus hand-written sequences for
// overlapping starts, reset during CALC and start-with-reset.
// Signed vectors are added when SEQ_DIVIDER_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_divider_if bus_if ();

    seq_divider dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs [10];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sgn_mode = 1'b0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start from IDLE and check latency, results and the DONE->IDLE step.
    task automatic run_div(input string nm, input logic [7:0] dvd, input logic [7:0] dvs,
                           input logic [7:0] eq, input logic [7:0] er, input logic edz,
                           input int elat);
        int lat;
        bus_if.dividend_i = dvd;
        bus_if.divisor_i  = dvs;
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus_if.signed_i   = sgn_mode;
`endif
        bus_if.start_i    = 1'b1;
        tick();
        bus_if.start_i    = 1'b0;
        lat = 1;
        while (bus_if.done_o !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({nm, " latency"},   lat, elat);
        check({nm, " quotient"},  {24'd0, bus_if.quotient_o}, {24'd0, eq});
        check({nm, " remainder"}, {24'd0, bus_if.remainder_o}, {24'd0, er});
        check({nm, " div_zero"},  {31'd0, bus_if.div_zero_o}, {31'd0, edz});
        check({nm, " busy_done"}, {31'd0, bus_if.busy_o}, 32'd1);
        tick();
        check({nm, " done_drop"}, {31'd0, bus_if.done_o}, 32'd0);
        check({nm, " busy_drop"}, {31'd0, bus_if.busy_o}, 32'd0);
        check({nm, " q_hold"},    {24'd0, bus_if.quotient_o}, {24'd0, eq});
    endtask

    initial begin
        logic seen;

        vecs[0] = '{dvd: 8'd100, dvs: 8'd7,   q: 8'd14,  r: 8'd2,   dz: 1'b0, lat: 9};
        vecs[1] = '{dvd: 8'd255, dvs: 8'd1,   q: 8'hFF,  r: 8'd0,   dz: 1'b0, lat: 9};
        vecs[2] = '{dvd: 8'd200, dvs: 8'd201, q: 8'd0,   r: 8'd200, dz: 1'b0, lat: 9};
        vecs[3] = '{dvd: 8'd5,   dvs: 8'd0,   q: 8'hFF,  r: 8'd5,   dz: 1'b1, lat: 1};
        vecs[4] = '{dvd: 8'd0,   dvs: 8'd5,   q: 8'd0,   r: 8'd0,   dz: 1'b0, lat: 9};
        vecs[5] = '{dvd: 8'd255, dvs: 8'd255, q: 8'd1,   r: 8'd0,   dz: 1'b0, lat: 9};
        vecs[6] = '{dvd: 8'd128, dvs: 8'd3,   q: 8'd42,  r: 8'd2,   dz: 1'b0, lat: 9};
        vecs[7] = '{dvd: 8'd7,   dvs: 8'd255, q: 8'd0,   r: 8'd7,   dz: 1'b0, lat: 9};
        vecs[8] = '{dvd: 8'd255, dvs: 8'd16,  q: 8'd15,  r: 8'd15,  dz: 1'b0, lat: 9};
        vecs[9] = '{dvd: 8'd200, dvs: 8'd100, q: 8'd2,   r: 8'd0,   dz: 1'b0, lat: 9};

        bus_if.start_i    = 1'b0;
        bus_if.dividend_i = 8'd0;
        bus_if.divisor_i  = 8'd0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus_if.signed_i   = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        check("rst busy",      {31'd0, bus_if.busy_o},      32'd0);
        check("rst done",      {31'd0, bus_if.done_o},      32'd0);
        check("rst quotient",  {24'd0, bus_if.quotient_o},  32'd0);
        check("rst remainder", {24'd0, bus_if.remainder_o}, 32'd0);
        check("rst div_zero",  {31'd0, bus_if.div_zero_o},  32'd0);
        rst = 1'b0;
        tick();

        // Table of unsigned vectors
        for (int i = 0; i < 10; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs,
                    vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);
        end

        // Start ignored in CALC (cycle 4) and in DONE (cycle 9)
        bus_if.dividend_i = 8'd100;
        bus_if.divisor_i  = 8'd7;
        bus_if.start_i    = 1'b1;
        tick();
        bus_if.start_i    = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("ovl busy c%0d", c), {31'd0, bus_if.busy_o}, (c <= 9) ? 32'd1 : 32'd0);
            check($sformatf("ovl done c%0d", c), {31'd0, bus_if.done_o}, (c == 9) ? 32'd1 : 32'd0);
            if (c >= 9) begin
                check($sformatf("ovl quot c%0d", c), {24'd0, bus_if.quotient_o},  32'd14);
                check($sformatf("ovl rem c%0d", c),  {24'd0, bus_if.remainder_o}, 32'd2);
            end
            bus_if.dividend_i = 8'd9;
            bus_if.divisor_i  = 8'd3;
            bus_if.start_i    = (c == 4 || c == 9) ? 1'b1 : 1'b0;
            tick();
        end
        bus_if.start_i = 1'b0;

        // Reset in the middle of CALC
        bus_if.dividend_i = 8'd100;
        bus_if.divisor_i  = 8'd7;
        bus_if.start_i    = 1'b1;
        tick();
        bus_if.start_i    = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy",      {31'd0, bus_if.busy_o},      32'd0);
        check("abort done",      {31'd0, bus_if.done_o},      32'd0);
        check("abort quotient",  {24'd0, bus_if.quotient_o},  32'd0);
        check("abort remainder", {24'd0, bus_if.remainder_o}, 32'd0);
        check("abort div_zero",  {31'd0, bus_if.div_zero_o},  32'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus_if.done_o !== 1'b0 || bus_if.busy_o !== 1'b0) seen = 1'b1;
            tick();
        end
        check("abort no activity", {31'd0, seen}, 32'd0);
        run_div("fresh 50/5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9);

        // Start asserted together with reset is dropped
        bus_if.dividend_i = 8'd5;
        bus_if.divisor_i  = 8'd0;
        bus_if.start_i    = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.start_i = 1'b0;
        check("rst+start busy",  {31'd0, bus_if.busy_o},     32'd0);
        check("rst+start done",  {31'd0, bus_if.done_o},     32'd0);
        check("rst+start quot",  {24'd0, bus_if.quotient_o}, 32'd0);
        tick();
        check("rst+start idle",  {31'd0, bus_if.busy_o},     32'd0);
        check("rst+start dz",    {31'd0, bus_if.div_zero_o}, 32'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        // Signed mode vectors
        sgn_mode = 1'b1;
        run_div("s -7/2",     8'hF9, 8'd2,  8'hFD, 8'hFF, 1'b0, 9);
        run_div("s -128/-1",  8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
        run_div("s 7/-2",     8'd7,  8'hFE, 8'hFD, 8'd1,  1'b0, 9);
        run_div("s -7/-2",    8'hF9, 8'hFE, 8'd3,  8'hFF, 1'b0, 9);
        sgn_mode = 1'b0;
        run_div("u 249/2",    8'hF9, 8'd2,  8'd124, 8'd1, 1'b0, 9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameters: none; operand width is fixed by package constant DATA_W = 8, matching the team's 8-bit adder/subtractor datapath.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  request a division; sampled only in IDLE.
REQ-006 dividend_i  input  8  dividend; captured on accepted start.
REQ-007 divisor_i  input  8  divisor; captured on accepted start.
REQ-008 busy_o  output  1  high while in CALC or DONE.
REQ-009 done_o  output  1  one-cycle pulse; results valid in that cycle.
REQ-010 quotient_o  output  8  registered quotient.
REQ-011 remainder_o  output  8  registered remainder.
REQ-012 div_zero_o  output  1  registered flag: last operation had divisor 0.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 Start acceptance: start_i=1 in IDLE SHALL latch both operands.
  - Divisor nonzero: clear partial remainder, load bit counter = 7, go to CALC.
  - Divisor zero: go directly to DONE.
REQ-015 start_i in CALC or DONE SHALL be ignored, with no effect on operands or state.
REQ-016 CALC SHALL perform one restoring-division step per cycle, MSB first, for exactly 8 cycles:
  - shifted value = {R, next dividend bit} (9 bits).
  - Low 8 bits minus divisor, computed by the single adder/subtractor in subtract mode.
  - Step succeeds when the shifted-out bit is 1 or the subtract carry-out is 1.
  - Success: R = difference, quotient bit = 1. Failure: R = low 8 bits unchanged, quotient bit = 0.
REQ-017 Leaving CALC: after the counter-0 step the FSM SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle: done_o=1, outputs hold final values, next state IDLE.
REQ-019 Latency: start accepted in cycle 0 SHALL give done_o in cycle 9 (nonzero divisor) or cycle 1 (zero divisor).
REQ-020 Divide by zero SHALL give quotient_o=0xFF, remainder_o=dividend, div_zero_o=1; otherwise div_zero_o=0.
REQ-021 quotient_o, remainder_o and div_zero_o SHALL hold stable from DONE until the next accepted start.
  - They SHALL NOT show intermediate CALC values.
REQ-022 start_i=1 in the cycle DONE is exited SHALL be ignored; the earliest new acceptance is the first IDLE cycle.

Reset
REQ-023 rst_i=1 SHALL force IDLE, busy_o=0, done_o=0, quotient_o=0, remainder_o=0, div_zero_o=0 and counter=0 on the next edge.
REQ-024 Reset SHALL take priority in every state, including mid-CALC; the aborted operation produces no done_o.
REQ-025 start_i asserted together with rst_i SHALL be ignored.

Configuration
REQ-026 Macro SEQ_DIVIDER_SIGNED_EN SHALL add input port signed_i (1 bit), sampled on accepted start.
REQ-027 With SEQ_DIVIDER_SIGNED_EN and signed_i=1:
  - Operands are two's complement; magnitudes are divided by the unsigned core.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - -128 / -1 SHALL yield quotient 0x80, remainder 0x00.
  - Latency is unchanged.
REQ-028 Without the macro, signed_i SHALL be absent and behaviour SHALL be purely unsigned as above.

Structure
REQ-029 Package div_pkg SHALL hold DATA_W=8, CNT_W=3 and the FSM state enum (IDLE, CALC, DONE).
REQ-030 The subtract step SHALL use one instance of the existing 8-bit adder/subtractor sub-module add_subtract.
  - add_sub tied to 1; its carry-out is used as the no-borrow indicator.
  - No other arithmetic unit SHALL be inferred for the step.

Verification
REQ-031 100 / 7 -> done_o 9 cycles after start; quotient 14 (0x0E), remainder 2, div_zero_o=0.
REQ-032 255 / 1 -> quotient 0xFF, remainder 0; 200 / 201 -> quotient 0, remainder 200.
REQ-033 5 / 0 -> done_o 1 cycle after start; quotient 0xFF, remainder 5, div_zero_o=1.
REQ-034 Start 100/7, then start 9/3 at cycle 4 -> second start ignored; result 14 r 2; busy_o high cycles 1-9.
REQ-035 rst_i pulsed at cycle 5 of CALC -> next cycle busy_o=0, all outputs 0, no done_o; a fresh 50/5 then gives 10 r 0.
REQ-036 SEQ_DIVIDER_SIGNED_EN builds only, signed_i=1:
  - -7 / 2 -> quotient 0xFD, remainder 0xFF.
  - -128 / -1 -> quotient 0x80, remainder 0.
